// File: rtl/l2_bank_arbiter_2ch.sv
// rtl/l2_bank_arbiter_2ch.sv - per-bank two-channel L2 request arbiter with CH0 starvation guard
module l2_bank_arbiter_2ch #(
    parameter int N_CH0      = 5,
    parameter int N_CH1      = 4,
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 64,
    parameter int BE_WIDTH   = DATA_WIDTH / 8,
    parameter int N_MASTER   = N_CH0 + N_CH1,
    parameter int ID_WIDTH   = N_MASTER,
    parameter int STARVE_MAX = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_MASTER-1:0]            req_i,
    input  logic [N_MASTER*ADDR_WIDTH-1:0] add_i,
    input  logic [N_MASTER-1:0]            wen_i,
    input  logic [N_MASTER*DATA_WIDTH-1:0] wdata_i,
    input  logic [N_MASTER*BE_WIDTH-1:0]   be_i,
    output logic [N_MASTER-1:0]            gnt_o,
    output logic                           mem_req_o,
    output logic [ADDR_WIDTH-1:0]          mem_add_o,
    output logic                           mem_wen_o,
    output logic [DATA_WIDTH-1:0]          mem_wdata_o,
    output logic [BE_WIDTH-1:0]            mem_be_o,
    output logic [ID_WIDTH-1:0]            mem_ID_o,
    input  logic                           mem_gnt_i,
    input  logic                           mem_r_valid_i,
    input  logic [ID_WIDTH-1:0]            mem_r_ID_i,
    output logic [N_MASTER-1:0]            r_valid_o
);

    localparam int P0W = (N_CH0 > 1) ? $clog2(N_CH0) : 1;
    localparam int P1W = (N_CH1 > 1) ? $clog2(N_CH1) : 1;
    localparam int IW  = (N_MASTER > 1) ? $clog2(N_MASTER) : 1;
    localparam int CW  = $clog2(STARVE_MAX + 1);

    typedef enum logic {CH1_PRIO, CH0_FORCED} fsm_t;

    fsm_t           state, state_next;
    logic [P0W-1:0] ptr0, ptr0_next, win0;
    logic [P1W-1:0] ptr1, ptr1_next, win1;
    logic [CW-1:0]  starve_cnt, starve_next;
    logic           any0, any1, sel_ch1, hs, hs0, loss;
    logic [IW-1:0]  win_sel;

    logic [ADDR_WIDTH-1:0] add_arr   [N_MASTER];
    logic [DATA_WIDTH-1:0] wdata_arr [N_MASTER];
    logic [BE_WIDTH-1:0]   be_arr    [N_MASTER];

    for (genvar g = 0; g < N_MASTER; g++) begin : g_unpack
        assign add_arr[g]   = add_i[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_arr[g] = wdata_i[g*DATA_WIDTH +: DATA_WIDTH];
        assign be_arr[g]    = be_i[g*BE_WIDTH +: BE_WIDTH];
    end

    // Round-robin winner per channel; scanning distances high-to-low leaves the nearest requester
    always_comb begin
        int idx;
        idx  = 0;
        win0 = '0;
        win1 = '0;
        any0 = |req_i[N_CH0-1:0];
        any1 = |req_i[N_MASTER-1:N_CH0];
        for (int k = N_CH0 - 1; k >= 0; k--) begin
            idx = int'(ptr0) + k;
            if (idx >= N_CH0) idx = idx - N_CH0;
            if (req_i[idx]) win0 = P0W'(idx);
        end
        for (int k = N_CH1 - 1; k >= 0; k--) begin
            idx = int'(ptr1) + k;
            if (idx >= N_CH1) idx = idx - N_CH1;
            if (req_i[N_CH0 + idx]) win1 = P1W'(idx);
        end
    end

    // Channel select, bank-side mux and zero-latency grant; everything is quiet during reset
    always_comb begin
        sel_ch1     = (state == CH1_PRIO) ? any1 : !any0;
        win_sel     = sel_ch1 ? (IW'(N_CH0) + IW'(win1)) : IW'(win0);
        mem_req_o   = 1'b0;
        mem_add_o   = '0;
        mem_wen_o   = 1'b0;
        mem_wdata_o = '0;
        mem_be_o    = '0;
        mem_ID_o    = '0;
        gnt_o       = '0;
        if (!rst && (any0 || any1)) begin
            mem_req_o   = 1'b1;
            mem_add_o   = add_arr[win_sel];
            mem_wen_o   = wen_i[win_sel];
            mem_wdata_o = wdata_arr[win_sel];
            mem_be_o    = be_arr[win_sel];
            mem_ID_o    = ID_WIDTH'(1) << win_sel;
            if (mem_gnt_i) gnt_o = N_MASTER'(1) << win_sel;
        end
        r_valid_o = (!rst && mem_r_valid_i) ? mem_r_ID_i : '0;
    end

    // Next-state: pointers move only on a handshake, starvation count tracks CH0 losses
    always_comb begin
        hs          = mem_req_o & mem_gnt_i;
        hs0         = hs & !sel_ch1;
        loss        = any0 & hs & sel_ch1;
        ptr0_next   = ptr0;
        ptr1_next   = ptr1;
        starve_next = starve_cnt;
        state_next  = state;
        if (hs0) ptr0_next = (win0 == P0W'(N_CH0 - 1)) ? '0 : win0 + P0W'(1);
        if (hs && sel_ch1) ptr1_next = (win1 == P1W'(N_CH1 - 1)) ? '0 : win1 + P1W'(1);
        if (hs0 || !any0) starve_next = '0;
        else if (loss && starve_cnt != CW'(STARVE_MAX)) starve_next = starve_cnt + CW'(1);
        case (state)
            CH1_PRIO:   if (loss && starve_next == CW'(STARVE_MAX)) state_next = CH0_FORCED;
            CH0_FORCED: if (hs0 || !any0) state_next = CH1_PRIO;
            default:    state_next = CH1_PRIO;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= CH1_PRIO;
            ptr0       <= '0;
            ptr1       <= '0;
            starve_cnt <= '0;
        end else begin
            state      <= state_next;
            ptr0       <= ptr0_next;
            ptr1       <= ptr1_next;
            starve_cnt <= starve_next;
        end
    end

endmodule
